systolic_sched: RTL and testbench
=================================

// Module: systolic_sched
// PURPOSE
//  Job sequencer for the 4x4 weight-stationary systolic_core. Latches a 512-bit weight set and
//  skews incoming 4-element activation vectors onto the array row inputs (inP1/5/9/13).
//  De-skews the Re1..Re4 column sums back into aligned 4x64 result vectors and buffers them
//  behind a valid/ready output. The array cannot stall, so input admission is credit-controlled.
// PARAMETERS
//  N          4   array dimension (fixed by systolic_core; parameterised for the package only)
//  DATA_W     32  activation/weight width
//  ACC_W      64  column-sum width
//  LAT        4   cycles from a row-0 value on arr_in[0] to its column-0 sum on arr_re[0]
//  OUT_DEPTH  8   result FIFO depth; also the total credit limit
// PORTS
//  clk        in   1          single clock
//  rst        in   1          reset: asynchronous, active-low
//  w_valid    in   1          weight set offered
//  w_ready    out  1          weight set accepted (IDLE only)
//  w_data     in   N*N*DATA_W w[r*N+j] at [(r*N+j)*32 +: 32]
//  x_valid    in   1          activation vector offered
//  x_ready    out  1          activation vector accepted
//  x_data     in   N*DATA_W   row r at [r*32 +: 32]
//  x_last     in   1          last vector of the job
//  arr_weight out  N*N*DATA_W to systolic_core weight_flat
//  arr_in     out  N*DATA_W   row r -> inP(4r+1), already skewed
//  arr_re     in   N*ACC_W    Re1..Re4, column j at [j*64 +: 64]
//  y_valid    out  1          result available
//  y_ready    in   1          result consumed
//  y_data     out  N*ACC_W    aligned column sums, column j at [j*64 +: 64]
//  y_last     out  1          result belongs to the vector that carried x_last
//  busy       out  1          state!=IDLE or inflight!=0
// BEHAVIOUR
//  Reset: state=IDLE, arr_weight=0, arr_in=0, wt_loaded=0, inflight=0, FIFO empty, all tags 0.
//   Outputs: w_ready=1, x_ready=0, y_valid=0, y_last=0, busy=0.
//  FSM:
//   IDLE   w_ready=1. A w handshake latches arr_weight, sets wt_loaded, and goes to LOAD.
//          If x_valid && !w_valid && wt_loaded, go to STREAM (weights reused).
//          If w_valid and x_valid are both high, the weight load wins.
//   LOAD   one settle cycle, then STREAM. w_ready=0.
//   STREAM x_ready = (inflight + fifo_count < OUT_DEPTH).
//          An accepted vector with x_last goes to DRAIN.
//   DRAIN  x_ready=0. Wait for inflight==0, then IDLE. FIFO contents remain valid across this.
//   w_ready=0 outside IDLE; weights never change while a vector is in flight.
//  Skew: a vector accepted at edge t drives row r on arr_in[r] from edge t+1+r, for one cycle.
//   Cycles with no accept inject 0 into row 0 (bubble). Zeros add nothing to any sum.
//  Tag pipe: {valid,last} shift register launched at accept.
//   Column j is sampled from arr_re at edge t+1+LAT+j and delayed N-1-j cycles (de-skew).
//   The aligned vector is written to the FIFO at edge t+LAT+N (default t+8).
//   It is visible on y_* after that edge. Bubble tags are never written.
//  Counters (width $clog2(OUT_DEPTH+1)):
//   inflight: +1 on accept, -1 on FIFO write, unchanged when both happen in one cycle.
//   fifo_count: +1 on write, -1 on y handshake, simultaneous -> unchanged.
//   A write always finds space (credit invariant). Assert fifo_count<=OUT_DEPTH.
//  Ordering: results leave strictly in acceptance order; y_data is held stable while y_valid && !y_ready.
//  Data is passed through unmodified: no arithmetic and no truncation in this block.
//  Reset mid-operation: in-flight tags and FIFO are cleared and stale array outputs are never emitted.
//   The weights must be reloaded before the next x accept.
// STRUCTURE
//  systolic_pkg: N, DATA_W, ACC_W; typedef enum logic[1:0] {IDLE,LOAD,STREAM,DRAIN} sched_state_t;
//   typedef logic [N-1:0][ACC_W-1:0] result_vec_t.
//  Sub-module: sync_fifo #(WIDTH=N*ACC_W+1, DEPTH=OUT_DEPTH), async active-low reset, count output.
//  Skew and de-skew lines are generate loops inside systolic_sched.
// TESTING (bench instantiates systolic_sched + systolic_core)
//  1 Identity weights, x=[1,2,3,4] with x_last, y_ready=1 -> y_data=[1,2,3,4], y_last=1, y_valid exactly 8 cycles after accept.
//  2 w[r*4+j]=r+1, 4 back-to-back vectors of all 2s, last on 4th -> each y=[20,20,20,20] on 4 consecutive cycles; y_last on 4th only; busy falls after.
//  3 y_ready=0, offer 10 vectors -> x_ready low after 8 accepts; release y_ready -> 10 results in order, none lost or duplicated.
//  4 Second job with no w handshake (x_valid only) -> STREAM reuses weights; w_valid asserted during STREAM sees w_ready=0 and arr_weight is unchanged.
//  5 rst low with 3 vectors in flight -> next cycle y_valid=0, arr_in=0, busy=0; after release no stale y_valid ever rises; x_valid alone stays unaccepted until weights are loaded.
//  6 w_valid and x_valid high together in IDLE with wt_loaded=1 -> weight load taken first (LOAD), x accepted in STREAM one cycle later.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared sizing, scheduler state encoding and result vector type for the systolic job sequencer.
package systolic_pkg;
  localparam int unsigned N         = 4;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ACC_W     = 64;
  localparam int unsigned LAT       = 4;
  localparam int unsigned OUT_DEPTH = 8;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} sched_state_t;

  typedef logic [N-1:0][ACC_W-1:0] result_vec_t;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head entry is presented on rd_data.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_ok, rd_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH[CW-1:0]);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = next_ptr(wr_ptr_q);
    if (rd_ok) rd_ptr_d = next_ptr(rd_ptr_q);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/systolic_sched.sv
// Job sequencer for the 4x4 weight-stationary array: weight latch, input skew, output de-skew,
// credit-limited admission and a result FIFO behind a valid/ready port.
module systolic_sched #(
  parameter int unsigned N         = systolic_pkg::N,
  parameter int unsigned DATA_W    = systolic_pkg::DATA_W,
  parameter int unsigned ACC_W     = systolic_pkg::ACC_W,
  parameter int unsigned LAT       = systolic_pkg::LAT,
  parameter int unsigned OUT_DEPTH = systolic_pkg::OUT_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [N*N*DATA_W-1:0]   w_data,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [N*DATA_W-1:0]     x_data,
  input  logic                    x_last,
  output logic [N*N*DATA_W-1:0]   arr_weight,
  output logic [N*DATA_W-1:0]     arr_in,
  input  logic [N*ACC_W-1:0]      arr_re,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic [N*ACC_W-1:0]      y_data,
  output logic                    y_last,
  output logic                    busy
);
  import systolic_pkg::*;

  localparam int unsigned CNT_W   = $clog2(OUT_DEPTH + 1);
  localparam int unsigned TAG_LEN = LAT + N;
  localparam logic [CNT_W:0] CREDITS = OUT_DEPTH[CNT_W:0];

  sched_state_t            state_q, state_d;
  logic [N*N*DATA_W-1:0]   wt_q, wt_d;
  logic                    wt_loaded_q, wt_loaded_d;
  logic [CNT_W-1:0]        inflight_q, inflight_d, fifo_count;
  logic [TAG_LEN-1:0]      tag_v_q, tag_v_d, tag_l_q, tag_l_d;
  logic                    x_acc, fifo_wr, y_fire, fifo_empty, fifo_full, head_last;
  logic [N*ACC_W-1:0]      aligned;

  assign x_acc      = x_valid && x_ready;
  assign fifo_wr    = tag_v_q[TAG_LEN-1];
  assign y_fire     = y_valid && y_ready;
  assign arr_weight = wt_q;
  assign busy       = (state_q != IDLE) || (inflight_q != '0);
  assign y_valid    = !fifo_empty;
  assign y_last     = y_valid && head_last;

  always_comb begin
    state_d     = state_q;
    wt_d        = wt_q;
    wt_loaded_d = wt_loaded_q;
    w_ready     = 1'b0;
    x_ready     = 1'b0;
    case (state_q)
      IDLE: begin
        w_ready = 1'b1;
        if (w_valid) begin
          wt_d        = w_data;
          wt_loaded_d = 1'b1;
          state_d     = LOAD;
        end else if (x_valid && wt_loaded_q) begin
          state_d = STREAM;
        end
      end
      LOAD:   state_d = STREAM;
      STREAM: begin
        x_ready = ({1'b0, inflight_q} + {1'b0, fifo_count}) < CREDITS;
        if (x_valid && x_ready && x_last) state_d = DRAIN;
      end
      DRAIN:   if (inflight_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tags track every pipeline slot so bubbles and post-reset array residue are never written.
  always_comb begin
    tag_v_d    = {tag_v_q[TAG_LEN-2:0], x_acc};
    tag_l_d    = {tag_l_q[TAG_LEN-2:0], x_acc && x_last};
    inflight_d = inflight_q;
    case ({x_acc, fifo_wr})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wt_q        <= '0;
      wt_loaded_q <= 1'b0;
      inflight_q  <= '0;
      tag_v_q     <= '0;
      tag_l_q     <= '0;
    end else begin
      state_q     <= state_d;
      wt_q        <= wt_d;
      wt_loaded_q <= wt_loaded_d;
      inflight_q  <= inflight_d;
      tag_v_q     <= tag_v_d;
      tag_l_q     <= tag_l_d;
    end
  end

  // Row r sits behind r+2 registers: one capture stage at accept plus r cycles of skew.
  for (genvar r = 0; r < N; r++) begin : g_skew
    localparam int unsigned LEN = r + 2;
    logic [DATA_W-1:0] line_q [LEN];
    logic [DATA_W-1:0] line_d [LEN];

    always_comb begin
      line_d[0] = x_acc ? x_data[r*DATA_W +: DATA_W] : '0;
      for (int unsigned k = 1; k < LEN; k++) line_d[k] = line_q[k-1];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int unsigned k = 0; k < LEN; k++) line_q[k] <= '0;
      end else begin
        line_q <= line_d;
      end
    end

    assign arr_in[r*DATA_W +: DATA_W] = line_q[LEN-1];
  end

  for (genvar j = 0; j < N; j++) begin : g_deskew
    if (j == N - 1) begin : g_direct
      assign aligned[j*ACC_W +: ACC_W] = arr_re[j*ACC_W +: ACC_W];
    end else begin : g_delay
      localparam int unsigned D = N - 1 - j;
      logic [ACC_W-1:0] dl_q [D];
      logic [ACC_W-1:0] dl_d [D];

      always_comb begin
        dl_d[0] = arr_re[j*ACC_W +: ACC_W];
        for (int unsigned k = 1; k < D; k++) dl_d[k] = dl_q[k-1];
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int unsigned k = 0; k < D; k++) dl_q[k] <= '0;
        end else begin
          dl_q <= dl_d;
        end
      end

      assign aligned[j*ACC_W +: ACC_W] = dl_q[D-1];
    end
  end

  sync_fifo #(
    .WIDTH (N*ACC_W + 1),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (fifo_wr),
    .wr_data ({tag_l_q[TAG_LEN-1], aligned}),
    .rd_en   (y_fire),
    .rd_data ({head_last, y_data}),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  a_fifo_bound: assert property (@(posedge clk) disable iff (!rst)
    fifo_count <= OUT_DEPTH[CNT_W-1:0]);
  a_write_space: assert property (@(posedge clk) disable iff (!rst)
    !(fifo_wr && fifo_full));
endmodule

// File: tb/tb_systolic_sched.sv
// Bench for systolic_sched with a behavioural weight-stationary array model on arr_in/arr_re.
module tb_systolic_sched;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         w_valid = 1'b0, w_ready;
  logic [511:0] w_data = '0;
  logic         x_valid = 1'b0, x_ready, x_last = 1'b0;
  logic [127:0] x_data = '0;
  logic [511:0] arr_weight;
  logic [127:0] arr_in;
  logic [255:0] arr_re;
  logic         y_valid, y_ready = 1'b0, y_last, busy;
  logic [255:0] y_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_sched #(.N(4), .DATA_W(32), .ACC_W(64), .LAT(4), .OUT_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
    .arr_weight(arr_weight), .arr_in(arr_in), .arr_re(arr_re),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last),
    .busy(busy)
  );

  // Array model: row r meets column j's sum LAT+j-1-r cycles after it appears on arr_in.
  logic [127:0] hist_q [1:6];
  always @(posedge clk) begin
    hist_q[1] <= arr_in;
    for (int k = 2; k <= 6; k++) hist_q[k] <= hist_q[k-1];
  end

  always_comb begin
    arr_re = '0;
    for (int j = 0; j < 4; j++) begin
      for (int r = 0; r < 4; r++) begin
        int d;
        logic [31:0] xv;
        d  = 3 + j - r;
        xv = (d == 0) ? arr_in[r*32 +: 32] : hist_q[d][r*32 +: 32];
        arr_re[j*64 +: 64] = arr_re[j*64 +: 64] + 64'(xv) * 64'(arr_weight[(r*4+j)*32 +: 32]);
      end
    end
  end

  typedef struct {
    int             wk;
    logic [127:0]   x;
    logic [255:0]   y;
  } vec_t;

  function automatic logic [511:0] mk_w(input int k);
    logic [511:0] w;
    logic [31:0]  v;
    w = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        case (k)
          0:       v = (r == j) ? 32'd1 : 32'd0;
          1:       v = 32'(r + 1);
          2:       v = 32'(r * 4 + j);
          default: v = 32'hFFFF_FFFF;
        endcase
        w[(r*4+j)*32 +: 32] = v;
      end
    end
    return w;
  endfunction

  function automatic logic [127:0] vec(input int k);
    return {32'(k + 300), 32'(k + 200), 32'(k + 100), 32'(k)};
  endfunction

  function automatic logic [255:0] ext(input logic [127:0] x);
    logic [255:0] y;
    for (int i = 0; i < 4; i++) y[i*64 +: 64] = 64'(x[i*32 +: 32]);
    return y;
  endfunction

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_w(input logic [511:0] w, output int t);
    bit ok;
    ok = 0;
    t = -1;
    w_valid = 1'b1;
    w_data  = w;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (w_ready) ok = 1;
      @(negedge clk);
    end
    w_valid = 1'b0;
    if (ok) t = cyc;
    check("w_accept", 512'(ok), 512'(1));
  endtask

  task automatic send_x(input logic [127:0] d, input logic last, output int t);
    bit ok;
    ok = 0;
    t = -1;
    x_valid = 1'b1;
    x_data  = d;
    x_last  = last;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (x_ready) ok = 1;
      @(negedge clk);
    end
    x_valid = 1'b0;
    x_last  = 1'b0;
    if (ok) t = cyc;
    check("x_accept", 512'(ok), 512'(1));
  endtask

  task automatic pop(input string nm, input logic [255:0] exp_y, input logic exp_last);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (y_valid) ok = 1;
      else @(negedge clk);
    end
    check({nm, "_valid"}, 512'(ok), 512'(1));
    if (ok) begin
      check({nm, "_data"}, 512'(y_data), 512'(exp_y));
      check({nm, "_last"}, 512'(y_last), 512'(exp_last));
      y_ready = 1'b1;
      @(negedge clk);
      y_ready = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 60 && (busy || y_valid); i++) @(negedge clk);
    check({nm, "_idle"}, 512'({busy, y_valid}), 512'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t         tbl [7];
    int           t, tw, lat, n, seen_y, seen_x;
    int           tk [4];
    int           yc [4];
    logic [255:0] yd [4];
    logic         yl [4];
    logic [255:0] twenty;

    twenty = {64'd20, 64'd20, 64'd20, 64'd20};
    tbl[0] = '{0, {32'd4, 32'd3, 32'd2, 32'd1}, {64'd4, 64'd3, 64'd2, 64'd1}};
    tbl[1] = '{1, {32'd2, 32'd2, 32'd2, 32'd2}, twenty};
    tbl[2] = '{2, {32'd1, 32'd1, 32'd1, 32'd1}, {64'd36, 64'd32, 64'd28, 64'd24}};
    tbl[3] = '{2, {32'd4, 32'd3, 32'd2, 32'd1}, {64'd110, 64'd100, 64'd90, 64'd80}};
    tbl[4] = '{3, {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF},
               {4{64'hFFFF_FFFE_0000_0001}}};
    tbl[5] = '{0, {32'd0, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF},
               {64'd0, 64'd7, 64'h8000_0000, 64'hFFFF_FFFF}};
    tbl[6] = '{2, {32'd0, 32'd0, 32'd0, 32'd1}, {64'd3, 64'd2, 64'd1, 64'd0}};

    repeat (3) @(negedge clk);
    check("rst_w_ready", 512'(w_ready), 512'(1));
    check("rst_x_ready", 512'(x_ready), 512'(0));
    check("rst_y_valid", 512'(y_valid), 512'(0));
    check("rst_y_last", 512'(y_last), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_arr_in", 512'(arr_in), 512'(0));
    check("rst_arr_weight", arr_weight, 512'(0));
    rst = 1'b1;
    @(negedge clk);

    // Single-vector jobs: data path and accept-to-valid latency.
    for (int i = 0; i < 7; i++) begin
      wait_idle("tbl");
      send_w(mk_w(tbl[i].wk), tw);
      send_x(tbl[i].x, 1'b1, t);
      lat = -1;
      for (int k = 0; k < 30 && lat < 0; k++) begin
        if (y_valid) lat = cyc - t;
        else @(negedge clk);
      end
      check($sformatf("tbl%0d_latency", i), 512'(lat), 512'(8));
      pop($sformatf("tbl%0d", i), tbl[i].y, 1'b1);
    end

    // Back-to-back job, results on consecutive cycles with y_ready held high.
    wait_idle("b2b");
    send_w(mk_w(1), tw);
    for (int k = 0; k < 4; k++) send_x({4{32'd2}}, k == 3, tk[k]);
    for (int k = 1; k < 4; k++) check($sformatf("b2b_accept%0d", k), 512'(tk[k] - tk[0]), 512'(k));
    y_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (y_valid && n < 4) begin
        yc[n] = cyc; yd[n] = y_data; yl[n] = y_last;
        if (n == 3) check("b2b_busy_at_last", 512'(busy), 512'(1));
        n++;
      end
      @(negedge clk);
    end
    y_ready = 1'b0;
    check("b2b_count", 512'(n), 512'(4));
    for (int k = 0; k < 4 && k < n; k++) begin
      check($sformatf("b2b_y%0d_cycle", k), 512'(yc[k] - tk[0]), 512'(8 + k));
      check($sformatf("b2b_y%0d_data", k), 512'(yd[k]), 512'(twenty));
      check($sformatf("b2b_y%0d_last", k), 512'(yl[k]), 512'(k == 3));
    end
    check("b2b_busy_after", 512'(busy), 512'(0));

    // Credit limit with a stalled consumer.
    wait_idle("credit");
    send_w(mk_w(0), tw);
    for (int k = 0; k < 8; k++) send_x(vec(k), 1'b0, t);
    repeat (12) @(negedge clk);
    check("credit_x_ready", 512'(x_ready), 512'(0));
    check("credit_head_held", 512'(y_data), 512'(ext(vec(0))));
    x_valid = 1'b1; x_data = vec(8);
    seen_x = 0;
    for (int i = 0; i < 5; i++) begin
      if (x_ready) seen_x++;
      @(negedge clk);
    end
    x_valid = 1'b0;
    check("credit_no_accept", 512'(seen_x), 512'(0));
    check("credit_head_stable", 512'(y_data), 512'(ext(vec(0))));
    pop("credit0", ext(vec(0)), 1'b0);
    pop("credit1", ext(vec(1)), 1'b0);
    send_x(vec(8), 1'b0, t);
    send_x(vec(9), 1'b1, t);
    for (int k = 2; k < 10; k++) pop($sformatf("credit%0d", k), ext(vec(k)), k == 9);
    seen_y = 0;
    for (int i = 0; i < 15; i++) begin
      if (y_valid) seen_y++;
      @(negedge clk);
    end
    check("credit_no_dup", 512'(seen_y), 512'(0));

    // Weight reuse without a w handshake; w_valid ignored during STREAM.
    wait_idle("reuse");
    send_x(vec(50), 1'b0, t);
    w_valid = 1'b1; w_data = mk_w(2);
    check("reuse_w_ready", 512'(w_ready), 512'(0));
    send_x(vec(51), 1'b1, t);
    check("reuse_w_ready_drain", 512'(w_ready), 512'(0));
    check("reuse_weights", arr_weight, mk_w(0));
    w_valid = 1'b0;
    pop("reuse0", ext(vec(50)), 1'b0);
    pop("reuse1", ext(vec(51)), 1'b1);

    // w and x offered together in IDLE: load first, accept two edges later.
    wait_idle("both");
    w_valid = 1'b1; w_data = mk_w(1);
    x_valid = 1'b1; x_data = {4{32'd2}}; x_last = 1'b1;
    check("both_w_ready", 512'(w_ready), 512'(1));
    @(negedge clk);
    tw = cyc;
    w_valid = 1'b0;
    check("both_load_weights", arr_weight, mk_w(1));
    check("both_load_x_ready", 512'(x_ready), 512'(0));
    send_x({4{32'd2}}, 1'b1, t);
    check("both_accept_delay", 512'(t - tw), 512'(2));
    pop("both", twenty, 1'b1);

    // Reset with vectors in flight.
    wait_idle("mrst");
    send_w(mk_w(0), tw);
    for (int k = 0; k < 3; k++) send_x(vec(20 + k), 1'b0, t);
    rst = 1'b0;
    #1;
    check("mrst_y_valid", 512'(y_valid), 512'(0));
    check("mrst_arr_in", 512'(arr_in), 512'(0));
    check("mrst_busy", 512'(busy), 512'(0));
    check("mrst_arr_weight", arr_weight, 512'(0));
    @(negedge clk);
    check("mrst_w_ready", 512'(w_ready), 512'(1));
    rst = 1'b1;
    x_valid = 1'b1; x_data = vec(7); x_last = 1'b1;
    seen_x = 0; seen_y = 0;
    for (int i = 0; i < 20; i++) begin
      if (x_ready) seen_x++;
      if (y_valid) seen_y++;
      @(negedge clk);
    end
    x_valid = 1'b0; x_last = 1'b0;
    check("mrst_no_stale_y", 512'(seen_y), 512'(0));
    check("mrst_x_blocked", 512'(seen_x), 512'(0));
    send_w(mk_w(0), tw);
    send_x(vec(7), 1'b1, t);
    pop("mrst_after", ext(vec(7)), 1'b1);
    wait_idle("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
